// File: rtl/mux4_reg.sv
// Registered 4-to-1 multiplexer with valid, select-echo and change flags.
// Optional even-parity output y_par is enabled by defining MUX_PARITY_EN.
module mux4_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [1:0]       y_sel,
`ifdef MUX_PARITY_EN
    output logic             y_par,
`endif
    output logic             y_chg
);

    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_y;
    logic [1:0]       r_sel;
    logic             r_valid;
    logic             r_chg;

    always_comb begin
        w_sel = a;
        case (s)
            2'd0:    w_sel = a;
            2'd1:    w_sel = b;
            2'd2:    w_sel = c;
            default: w_sel = d;
        endcase
    end

    // y_chg compares against the value held before this edge; reset clears it to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_chg   <= 1'b0;
        end else if (en) begin
            r_y     <= w_sel;
            r_sel   <= s;
            r_valid <= 1'b1;
            r_chg   <= (w_sel != r_y);
        end else begin
            r_valid <= 1'b0;
            r_chg   <= 1'b0;
        end
    end

`ifdef MUX_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_par <= 1'b0;
        else if (en)
            r_par <= ^w_sel;
    end

    assign y_par = r_par;
`endif

    assign y       = r_y;
    assign y_sel   = r_sel;
    assign y_valid = r_valid;
    assign y_chg   = r_chg;

endmodule

// File: tb/tb_mux4_reg.sv
// Self-checking bench for mux4_reg: directed steps followed by randomized
// traffic, compared against an array-indexed reference model.
module tb_mux4_reg;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [WIDTH-1:0] a, b, c, d;
    logic [1:0]       s;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic [1:0]       y_sel;
    logic             y_chg;
`ifdef MUX_PARITY_EN
    logic             y_par;
`endif

    mux4_reg #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .s       (s),
        .y       (y),
        .y_valid (y_valid),
        .y_sel   (y_sel),
`ifdef MUX_PARITY_EN
        .y_par   (y_par),
`endif
        .y_chg   (y_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int unsigned m_y;
    int unsigned m_sel;
    int unsigned m_valid;
    int unsigned m_chg;
    int unsigned m_par;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".y"},       32'(y),       m_y);
        check({tag, ".y_valid"}, 32'(y_valid), m_valid);
        check({tag, ".y_sel"},   32'(y_sel),   m_sel);
        check({tag, ".y_chg"},   32'(y_chg),   m_chg);
`ifdef MUX_PARITY_EN
        check({tag, ".y_par"},   32'(y_par),   m_par);
`endif
    endtask

    task automatic model_reset();
        m_y = 0; m_sel = 0; m_valid = 0; m_chg = 0; m_par = 0;
    endtask

    // Drive inputs, take one rising edge, advance the model, then sample #1 later.
    task automatic step(input string tag, input bit i_en,
                        input int unsigned ia, input int unsigned ib,
                        input int unsigned ic, input int unsigned id,
                        input int unsigned is);
        int unsigned data [4];
        int unsigned pick;
        en = i_en;
        a = WIDTH'(ia); b = WIDTH'(ib); c = WIDTH'(ic); d = WIDTH'(id);
        s = 2'(is);
        data[0] = ia % 16; data[1] = ib % 16; data[2] = ic % 16; data[3] = id % 16;
        @(posedge clk);
        if (i_en) begin
            pick    = data[is % 4];
            m_chg   = (pick != m_y) ? 1 : 0;
            m_y     = pick;
            m_sel   = is % 4;
            m_valid = 1;
            m_par   = $countones(pick) % 2;
        end else begin
            m_valid = 0;
            m_chg   = 0;
        end
        #1;
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0; a = '0; b = '0; c = '0; d = '0; s = '0;
        model_reset();
        #1;
        check_all("por");
        #2 rst_n = 1'b1;

        // mid-run reset discards a held y=4
        step("pre4", 1'b1, 0, 0, 0, 4, 3);
        check("pre4.y_lit", 32'(y), 4);
        async_reset("midrst");
        step("first", 1'b1, 1, 0, 0, 0, 0);
        check("first.y_lit", 32'(y), 1);

        // forward sweep
        step("sw0", 1'b1, 1, 2, 3, 4, 0);
        step("sw1", 1'b1, 1, 2, 3, 4, 1);
        step("sw2", 1'b1, 1, 2, 3, 4, 2);
        step("sw3", 1'b1, 1, 2, 3, 4, 3);
        check("sw3.y_lit", 32'(y), 4);

        // reverse sweep with new data
        step("rv3", 1'b1, 5, 6, 7, 8, 3);
        step("rv2", 1'b1, 5, 6, 7, 8, 2);
        check("rv2.y_lit", 32'(y), 7);
        step("rv1", 1'b1, 5, 6, 7, 8, 1);
        step("rv0", 1'b1, 5, 6, 7, 8, 0);
        check("rv0.y_lit", 32'(y), 5);

        // non-contiguous select, then repeat with no change
        step("nc0", 1'b1, 9, 12, 13, 14, 0);
        step("nc2", 1'b1, 9, 12, 13, 14, 2);
        step("nc2r", 1'b1, 9, 12, 13, 14, 2);
        check("nc2r.y_chg_lit", 32'(y_chg), 0);

        // hold with en=0
        step("hold0", 1'b0, 9, 12, 13, 0, 3);
        step("hold1", 1'b0, 9, 12, 13, 0, 1);
        check("hold1.y_lit", 32'(y), 13);
        check("hold1.sel_lit", 32'(y_sel), 2);
        step("reen", 1'b1, 9, 12, 13, 0, 3);
        step("p12", 1'b1, 9, 12, 13, 0, 1);
`ifdef MUX_PARITY_EN
        check("p12.par_lit", 32'(y_par), 0);
`endif

        // randomized traffic with occasional async reset
        for (int unsigned i = 0; i < 300; i++) begin
            if ($urandom_range(0, 29) == 0)
                async_reset("rnd_rst");
            step("rnd", ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
